seq_engine: RTL and testbench

- Parametrised successor to the fixed 16-step one-hot sequence decoder in the game datapath.
- Generates a pseudo-random one-hot lane sequence from a seed, plays back growing prefixes on the LEDs, and checks player presses against each prefix.
- Sits between the tick prescaler and button debouncers on the input side, and the LED drivers and score display on the output side.

---
 rtl/seq_engine_if.sv | 29 ++
 rtl/seq_engine.sv | 195 +++++++++++++++++++
 tb/tb_seq_engine.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_engine_if.sv
// Handshake bundle between the game controller and seq_engine.
// master drives ticks, game control and presses; slave (the engine) drives the display/status.
interface seq_engine_if #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned ADDR_W = 4
) ();
    logic              tick;
    logic              start;
    logic [7:0]        seed;
    logic              abort;
    logic [LANES-1:0]  btn;
    logic              btn_valid;
    logic [LANES-1:0]  led;
    logic [ADDR_W:0]   round;
    logic              busy;
    logic              waiting;
    logic              fail;
    logic              win;

    modport master (
        output tick, start, seed, abort, btn, btn_valid,
        input  led, round, busy, waiting, fail, win
    );

    modport slave (
        input  tick, start, seed, abort, btn, btn_valid,
        output led, round, busy, waiting, fail, win
    );
endinterface

// File: rtl/seq_engine.sv
// Sequence game engine: fills a one-hot lane table from an 8-bit Galois LFSR, plays back
// growing prefixes on the LEDs and checks the player's presses against each prefix.
module seq_engine #(
    parameter int unsigned LANES         = 4,
    parameter int unsigned LANE_W        = 2,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned HOLD_TICKS    = 2,
    parameter int unsigned TIMEOUT_TICKS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_engine_if.slave bus
);
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned RW     = ADDR_W + 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [ADDR_W-1:0] K_LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [RW-1:0]     DEPTH_R   = RW'(DEPTH);
    localparam logic [RW-1:0]     ROUND_ONE = RW'(1);

    typedef enum logic [2:0] {
        StIdle, StGen, StPlayOn, StPlayOff, StInput, StFail, StWin
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d, lfsr_adv;
    logic [ADDR_W-1:0]  k_q, k_d;
    logic [RW-1:0]      step_q, step_d, step_inc;
    logic [RW-1:0]      round_q, round_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [LANES-1:0]   led_q, led_d;
    logic               busy_q, waiting_q, fail_q, win_q;

    logic [LANES-1:0]   mem [DEPTH];
    logic               mem_we;
    logic [LANES-1:0]   gen_lane;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        k_d      = k_q;
        step_d   = step_q;
        round_d  = round_q;
        hold_d   = hold_q;
        to_d     = to_q;
        led_d    = '0;
        mem_we   = 1'b0;
        lfsr_adv = lfsr_q[0] ? ((lfsr_q >> 1) ^ 8'hB8) : (lfsr_q >> 1);
        gen_lane = '0;
        gen_lane[lfsr_adv[LANE_W-1:0]] = 1'b1;
        step_inc = step_q + 1'b1;

        // abort wins over everything; the LFSR keeps its value
        if (bus.abort) begin
            state_d = StIdle;
            k_d     = '0;
            step_d  = '0;
            round_d = '0;
            hold_d  = '0;
            to_d    = '0;
        end else begin
            unique case (state_q)
                StIdle, StFail, StWin: begin
                    if (bus.start) begin
                        lfsr_d  = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
                        k_d     = '0;
                        step_d  = '0;
                        round_d = '0;
                        hold_d  = '0;
                        to_d    = '0;
                        state_d = StGen;
                    end
                end
                StGen: begin
                    lfsr_d = lfsr_adv;
                    mem_we = 1'b1;
                    k_d    = k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        round_d = ROUND_ONE;
                        step_d  = '0;
                        hold_d  = '0;
                        led_d   = mem[0];
                        state_d = StPlayOn;
                    end
                end
                StPlayOn: begin
                    led_d = mem[step_q[ADDR_W-1:0]];
                    if (bus.tick) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_d  = '0;
                            led_d   = '0;
                            state_d = StPlayOff;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                StPlayOff: begin
                    if (bus.tick) begin
                        if (step_inc == round_q) begin
                            step_d  = '0;
                            to_d    = '0;
                            state_d = StInput;
                        end else begin
                            step_d  = step_inc;
                            led_d   = mem[step_inc[ADDR_W-1:0]];
                            state_d = StPlayOn;
                        end
                    end
                end
                StInput: begin
                    // a press in the same cycle as a tick swallows the tick
                    if (bus.btn_valid) begin
                        to_d = '0;
                        if (bus.btn == mem[step_q[ADDR_W-1:0]]) begin
                            if (step_inc == round_q) begin
                                step_d = '0;
                                if (round_q == DEPTH_R) begin
                                    state_d = StWin;
                                end else begin
                                    round_d = round_q + 1'b1;
                                    hold_d  = '0;
                                    led_d   = mem[0];
                                    state_d = StPlayOn;
                                end
                            end else begin
                                step_d = step_inc;
                                led_d  = bus.btn;
                            end
                        end else begin
                            state_d = StFail;
                        end
                    end else if (bus.tick) begin
                        if (to_q == TO_LAST) begin
                            state_d = StFail;
                        end else begin
                            to_d = to_q + 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            lfsr_q    <= 8'h01;
            k_q       <= '0;
            step_q    <= '0;
            round_q   <= '0;
            hold_q    <= '0;
            to_q      <= '0;
            led_q     <= '0;
            busy_q    <= 1'b0;
            waiting_q <= 1'b0;
            fail_q    <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            k_q       <= k_d;
            step_q    <= step_d;
            round_q   <= round_d;
            hold_q    <= hold_d;
            to_q      <= to_d;
            led_q     <= led_d;
            busy_q    <= (state_d == StGen) || (state_d == StPlayOn) || (state_d == StPlayOff);
            waiting_q <= (state_d == StInput);
            fail_q    <= (state_d == StFail);
            win_q     <= (state_d == StWin);
        end
    end

    // table contents are meaningless until GEN has refilled them, so no reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[k_q] <= gen_lane;
        end
    end

    assign bus.led     = led_q;
    assign bus.round   = round_q;
    assign bus.busy    = busy_q;
    assign bus.waiting = waiting_q;
    assign bus.fail    = fail_q;
    assign bus.win     = win_q;
endmodule

// File: tb/tb_seq_engine.sv
// Directed bench for seq_engine: playback prefixes are queued from an LFSR model and
// popped as each lane lights; presses, failures, timeouts, abort and reset are checked.
module tb_seq_engine;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_engine_if #(.LANES(4), .ADDR_W(4)) bus ();

    seq_engine #(
        .LANES(4), .LANE_W(2), .DEPTH(16), .ADDR_W(4), .HOLD_TICKS(2), .TIMEOUT_TICKS(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] seq_m[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    task automatic build_model(input logic [7:0] s);
        logic [7:0] l;
        l = (s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < 16; i++) begin
            l = lfsr_next(l);
            seq_m[i] = 4'b0001 << l[1:0];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input logic [7:0] s, output int gen_cyc);
        build_model(s);
        bus.seed  = s;
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        chk("start_busy", bus.busy, 1);
        gen_cyc = 0;
        while (bus.led == 4'b0000 && gen_cyc < 100) begin
            cycle();
            gen_cyc++;
        end
    endtask

    // tick every third cycle; queue the prefix and pop each time a lane lights
    task automatic play_round(input int r);
        int         on_t  = 0;
        int         off_t = 0;
        int         cyc   = 0;
        logic [3:0] prev  = 4'b0000;
        logic [3:0] e;
        for (int i = 0; i < r; i++) exp_q.push_back(seq_m[i]);
        while (!bus.waiting && cyc < 2000) begin
            if (bus.led != 4'b0000 && prev == 4'b0000) begin
                chk($sformatf("r%0d_extra_step", r), exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("r%0d_led", r), bus.led, e);
                end
            end
            prev     = bus.led;
            bus.tick = (cyc % 3 == 0);
            if (bus.tick) begin
                if (bus.led != 4'b0000) on_t++;
                else off_t++;
            end
            cycle();
            cyc++;
        end
        bus.tick = 1'b0;
        chk($sformatf("r%0d_play_bound", r), cyc < 2000, 1);
        chk($sformatf("r%0d_missing_steps", r), exp_q.size(), 0);
        chk($sformatf("r%0d_on_ticks", r), on_t, 2 * r);
        chk($sformatf("r%0d_off_ticks", r), off_t, r);
        chk($sformatf("r%0d_round", r), bus.round, r);
        exp_q.delete();
    endtask

    task automatic press(input logic [3:0] b);
        bus.btn       = b;
        bus.btn_valid = 1'b1;
        cycle();
        bus.btn_valid = 1'b0;
        bus.btn       = 4'b0000;
    endtask

    task automatic press_round(input int r);
        for (int i = 0; i < r; i++) begin
            press(seq_m[i]);
            if (i < r - 1) begin
                chk($sformatf("r%0d_echo", r), bus.led, seq_m[i]);
                chk($sformatf("r%0d_still_waiting", r), bus.waiting, 1);
            end
        end
        if (r < 16) begin
            chk($sformatf("r%0d_next_round", r), bus.round, r + 1);
            chk($sformatf("r%0d_replay_busy", r), bus.busy, 1);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            cycle();
            bus.tick = 1'b0;
            cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        bus.tick      = 1'b0;
        bus.start     = 1'b0;
        bus.seed      = 8'h00;
        bus.abort     = 1'b0;
        bus.btn       = 4'b0000;
        bus.btn_valid = 1'b0;

        // reset state
        #12;
        chk("rst_led", bus.led, 0);
        chk("rst_round", bus.round, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_waiting", bus.waiting, 0);
        chk("rst_fail", bus.fail, 0);
        chk("rst_win", bus.win, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // full game to WIN
        start_game(8'h01, g);
        chk("gen_len", g, 16);
        chk("first_led", bus.led, 4'b0001);
        for (int r = 1; r <= 16; r++) begin
            play_round(r);
            press_round(r);
        end
        chk("win_flag", bus.win, 1);
        chk("win_round", bus.round, 16);
        chk("win_led", bus.led, 0);
        chk("win_waiting", bus.waiting, 0);

        // wrong lane in round 3
        start_game(8'h01, g);
        for (int r = 1; r <= 2; r++) begin
            play_round(r);
            press_round(r);
        end
        play_round(3);
        press(seq_m[0]);
        press(seq_m[1]);
        press(4'b0010);
        chk("wrong_fail", bus.fail, 1);
        chk("wrong_round", bus.round, 3);
        chk("wrong_led", bus.led, 0);
        chk("wrong_waiting", bus.waiting, 0);

        // multi-hot press
        start_game(8'h01, g);
        play_round(1);
        press(4'b0011);
        chk("multihot_fail", bus.fail, 1);
        chk("multihot_round", bus.round, 1);

        // timeout on the 8th idle tick
        start_game(8'h01, g);
        play_round(1);
        tick_n(7);
        chk("to7_fail", bus.fail, 0);
        chk("to7_waiting", bus.waiting, 1);
        bus.tick = 1'b1;
        cycle();
        bus.tick = 1'b0;
        chk("to8_fail", bus.fail, 1);
        chk("to8_waiting", bus.waiting, 0);

        // press on the 7th tick clears the count and swallows the tick
        start_game(8'h01, g);
        play_round(1);
        press_round(1);
        play_round(2);
        tick_n(6);
        bus.tick = 1'b1;
        press(seq_m[0]);
        bus.tick = 1'b0;
        chk("tickpress_fail", bus.fail, 0);
        chk("tickpress_echo", bus.led, seq_m[0]);
        tick_n(7);
        chk("tickpress_7_fail", bus.fail, 0);
        chk("tickpress_7_waiting", bus.waiting, 1);
        bus.tick = 1'b1;
        cycle();
        bus.tick = 1'b0;
        chk("tickpress_8_fail", bus.fail, 1);

        // seed 0 behaves as seed 1; start during PLAY_ON is ignored
        start_game(8'h00, g);
        chk("seed0_gen_len", g, 16);
        chk("seed0_first_led", bus.led, 4'b0001);
        bus.seed  = 8'h5A;
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        chk("ignored_start_led", bus.led, seq_m[0]);
        chk("ignored_start_round", bus.round, 1);
        for (int r = 1; r <= 3; r++) begin
            play_round(r);
            press_round(r);
        end
        play_round(4);

        // abort + start together in INPUT
        bus.abort = 1'b1;
        bus.start = 1'b1;
        cycle();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_round", bus.round, 0);
        chk("abort_waiting", bus.waiting, 0);
        chk("abort_busy", bus.busy, 0);
        cycle();
        cycle();
        chk("abort_stays_idle", bus.busy, 0);

        // asynchronous reset during PLAY_ON
        start_game(8'h01, g);
        chk("pre_rst_led", bus.led, 4'b0001);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", bus.led, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_round", bus.round, 0);
        #3;
        rst_n = 1'b1;
        cycle();
        start_game(8'h01, g);
        chk("post_rst_gen_len", g, 16);
        play_round(1);
        press_round(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
